// File: rtl/stream_credit_tx_if.sv
// Local producer handshake, remote FIFO write port and credit/status signals of stream_credit_tx.
// The slave modport is the transmitter's view; the master modport is the surrounding logic's view.
interface stream_credit_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDIT_NUM = 4
);
  localparam int CNT_WIDTH = $clog2(CREDIT_NUM + 1);

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  tx_valid_o;
  logic [DATA_WIDTH-1:0] tx_data_o;
  logic                  credit_return_i;
  logic [CNT_WIDTH-1:0]  credit_cnt_o;
  logic                  idle_o;
  logic                  err_o;

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  credit_return_i,
    output in_ready_o,
    output tx_valid_o,
    output tx_data_o,
    output credit_cnt_o,
    output idle_o,
    output err_o
  );

  modport master (
    output in_valid_i,
    output in_data_i,
    output credit_return_i,
    input  in_ready_o,
    input  tx_valid_o,
    input  tx_data_o,
    input  credit_cnt_o,
    input  idle_o,
    input  err_o
  );
endinterface

// File: rtl/stream_credit_tx.sv
// Credit-gated transmitter into a remote FIFO; accept -> tx_valid after TX_LATENCY cycles.
// Producer is stalled only when no credit remains; the remote side never backpressures.
module stream_credit_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDIT_NUM = 4,
  parameter int TX_LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  stream_credit_tx_if.slave bus
);
  localparam int CNT_WIDTH = $clog2(CREDIT_NUM + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CREDIT_NUM);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  credit_cnt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  err_set;
  logic                  err_q;
  logic                  accept;
  logic [TX_LATENCY-1:0] vld_pipe;
  logic [DATA_WIDTH-1:0] dat_pipe [TX_LATENCY];

  // Ready comes straight from the registered count, so a returned credit is usable next cycle.
  assign bus.in_ready_o = (credit_cnt != '0);
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  always_comb begin
    cnt_nxt = credit_cnt;
    err_set = 1'b0;
    if (accept && !bus.credit_return_i) begin
      cnt_nxt = credit_cnt - CNT_ONE;
    end else if (!accept && bus.credit_return_i) begin
      if (credit_cnt == CNT_FULL) begin
        err_set = 1'b1;
      end else begin
        cnt_nxt = credit_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CNT_FULL;
      err_q      <= 1'b0;
    end else begin
      credit_cnt <= cnt_nxt;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Each data stage only moves with its valid bit so tx_data_o holds the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < TX_LATENCY; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= accept;
      if (accept) begin
        dat_pipe[0] <= bus.in_data_i;
      end
      for (int i = 1; i < TX_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          dat_pipe[i] <= dat_pipe[i-1];
        end
      end
    end
  end

  assign bus.tx_valid_o   = vld_pipe[TX_LATENCY-1];
  assign bus.tx_data_o    = dat_pipe[TX_LATENCY-1];
  assign bus.credit_cnt_o = credit_cnt;
  assign bus.err_o        = err_q;
  assign bus.idle_o       = (credit_cnt == CNT_FULL) && (vld_pipe == '0);
endmodule
